mem_stage_hs: RTL and testbench
===============================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised MEM stage for the VLIW pipeline, between the EX/MEM register (p3_*) and WB (p4_*).
//  Carries N_ALU ALU result slots through to WB and runs one load/store slot against an external data memory.
//  The memory port uses a req/ack handshake and tolerates any memory latency; upstream is stalled while it waits.
//  Supports byte/half/word accesses, sign/zero-extended loads, byte-enabled stores and misalignment flagging.
// PARAMETERS
//  N_ALU  2   number of ALU result slots passed through
//  RW     3   register-index width
//  AW     32  memory address width
//  DW     32  data width (fixed at 32; other values unsupported)
// PORTS
//  clk               in   1        clock, all state on rising edge
//  reset             in   1        synchronous, active-low reset
//  p3_valid          in   1        p3 bundle holds a live instruction
//  p3_alu_rd         in   N_ALU*RW ALU slot destinations, slot i at [i*RW +: RW]
//  p3_alu_aluOut     in   N_ALU*DW ALU slot results
//  p3_mem_rd         in   RW       load destination register
//  p3_mem_op         in   2        00 none, 01 load, 10 store, 11 none
//  p3_mem_size       in   2        00 byte, 01 half, 10 word, 11 word
//  p3_mem_signed     in   1        1 = sign-extend load result
//  p3_mem_address    in   AW       EX-computed address
//  p3_mem_wdata      in   DW       store data (low bytes used for byte/half)
//  f_mem_address_sel in   1        1 = use forwarded address
//  f_mem_address     in   AW       forwarded address
//  stall             out  1        upstream must hold p3_* stable while 1
//  dm_req/dm_we      out  1/1      memory request / write strobe
//  dm_addr           out  AW       word-aligned address (addr[1:0]=0)
//  dm_wdata/dm_be    out  DW/4     store data in lane position / byte enables
//  dm_ack            in   1        memory completes request this cycle
//  dm_rdata          in   DW       read word, valid when dm_ack=1
//  p4_valid          out  1        WB bundle valid
//  p4_alu_rd/aluOut  out  N_ALU*RW / N_ALU*DW  registered ALU slots
//  p4_mem_rd         out  RW       load destination (0 if not a load)
//  p4_mem_wen        out  1        1 = WB writes p4_mem_out to p4_mem_rd
//  p4_mem_out        out  DW       extended load data
//  p4_misalign       out  1        access was misaligned and dropped
// BEHAVIOUR
//  Reset (reset=0 at edge): state IDLE; every p4_* output, dm_req, dm_we, dm_be zero. Reset in BUSY abandons the access; dm_req is 0 from the next cycle and any late dm_ack is ignored.
//  addr = f_mem_address_sel ? f_mem_address : p3_mem_address, evaluated only in IDLE.
//  Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//  FSM IDLE:
//   - p3_valid and (op none, or misaligned load/store): stall=0; p4 loads at edge (latency 1). Misaligned gives p4_misalign=1, p4_mem_wen=0 and no request.
//   - p3_valid with aligned load/store: stall=1 (combinational). Latch addr/op/size/signed/wdata/rd and all ALU slots; next state BUSY; p4_valid<=0.
//   - p3_valid=0: p4_valid<=0.
//  FSM BUSY:
//   - dm_req=1 and dm_addr/dm_we/dm_be/dm_wdata from latched values, held stable until ack.
//   - dm_ack=0: stall=1, p4_valid<=0.
//   - dm_ack=1: stall=0; p4 loads latched ALU slots and memory result; next state IDLE. Ack in the first BUSY cycle is legal (min load latency 2).
//  Store: dm_be byte=1<<a[1:0], half=a[1]?1100:0011, word=1111. Data replicated into lanes. p4_mem_wen=0, p4_mem_rd=0.
//  Load: pick byte lane a[1:0] or half lane a[1], extend per p3_mem_signed. p4_mem_wen=1.
//  Bubble (p4_valid=0): p4_mem_wen=0, all other p4 data undefined-but-stable (hold previous).
// TESTING
//  1 ALU-only: valid, op=00, slot0 rd=3/0x12345678 -> next cycle p4_valid=1, slot0 equal, stall never 1.
//  2 Signed byte load addr 0x103, ack after 3 cycles with rdata 0x80FF_FF00 -> stall=1 for 4 cycles; dm_addr=0x100; p4_mem_out=0xFFFFFF80, p4_mem_wen=1.
//  3 Half store 0xBEEF at 0x202 -> dm_we=1, dm_be=1100, dm_wdata[31:16]=0xBEEF; p4_mem_wen=0.
//  4 Word load at 0x101 -> no dm_req, stall=0, p4_misalign=1, p4_mem_wen=0.
//  5 f_mem_address_sel=1, f=0x40 vs p3=0x80, zero-ext half load with ack in first BUSY cycle -> dm_addr=0x40, total latency 2.
//  6 Reset asserted mid-BUSY then dm_ack -> dm_req=0, p4_valid=0, state IDLE, ack has no effect.

Source files
------------

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: VLIW MEM stage passing ALU slots to WB and running one load/store slot over a req/ack data-memory port.
// Ports:
//   clk, reset (sync, active-low)
//   p3_*          EX/MEM bundle: valid, ALU slots (rd/aluOut), mem rd/op/size/signed/address/wdata
//   f_mem_address_sel / f_mem_address   forwarded address override
//   stall         upstream holds p3_* while high
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be  memory request (held stable until dm_ack)
//   dm_ack/dm_rdata                      memory completion and read word
//   p4_*          WB bundle: valid, ALU slots, mem rd/wen/out, misalign flag
module mem_stage_hs #(
   parameter int N_ALU = 2,
   parameter int RW = 3,
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                p3_valid,
   input  logic [N_ALU*RW-1:0] p3_alu_rd,
   input  logic [N_ALU*DW-1:0] p3_alu_aluOut,
   input  logic [RW-1:0]       p3_mem_rd,
   input  logic [1:0]          p3_mem_op,
   input  logic [1:0]          p3_mem_size,
   input  logic                p3_mem_signed,
   input  logic [AW-1:0]       p3_mem_address,
   input  logic [DW-1:0]       p3_mem_wdata,
   input  logic                f_mem_address_sel,
   input  logic [AW-1:0]       f_mem_address,
   output logic                stall,
   output logic                dm_req,
   output logic                dm_we,
   output logic [AW-1:0]       dm_addr,
   output logic [DW-1:0]       dm_wdata,
   output logic [3:0]          dm_be,
   input  logic                dm_ack,
   input  logic [DW-1:0]       dm_rdata,
   output logic                p4_valid,
   output logic [N_ALU*RW-1:0] p4_alu_rd,
   output logic [N_ALU*DW-1:0] p4_alu_aluOut,
   output logic [RW-1:0]       p4_mem_rd,
   output logic                p4_mem_wen,
   output logic [DW-1:0]       p4_mem_out,
   output logic                p4_misalign
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   logic [0:0]          state;
   logic [AW-1:0]       addr;
   logic [AW-1:0]       l_addr;
   logic                l_we;
   logic                l_signed;
   logic [1:0]          l_size;
   logic [DW-1:0]       l_wdata;
   logic [RW-1:0]       l_rd;
   logic [N_ALU*RW-1:0] l_alu_rd;
   logic [N_ALU*DW-1:0] l_alu_out;
   logic                is_mem;
   logic                mis;
   logic                start;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [DW-1:0]       ld_data;
   assign addr = f_mem_address_sel ? f_mem_address : p3_mem_address;
   assign is_mem = p3_mem_op == 2'b01 || p3_mem_op == 2'b10;
   assign mis = p3_mem_size == 2'b01 ? addr[0] : p3_mem_size[1] && addr[1:0] != 2'b00;
   // only aligned memory ops leave IDLE; misaligned ones retire immediately as dropped
   assign start = state == IDLE && p3_valid && is_mem && !mis;
   assign stall = start || (state == BUSY && !dm_ack);
   assign dm_req = state == BUSY;
   assign dm_we = dm_req && l_we;
   assign dm_addr = {l_addr[AW-1:2], 2'b00};
   assign dm_be = !dm_req ? 4'b0000 :
                  l_size == 2'b00 ? 4'b0001 << l_addr[1:0] :
                  l_size == 2'b01 ? (l_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign dm_wdata = l_size == 2'b00 ? {4{l_wdata[7:0]}} :
                     l_size == 2'b01 ? {2{l_wdata[15:0]}} : l_wdata;
   assign ld_byte = dm_rdata[{l_addr[1:0], 3'b000} +: 8];
   assign ld_half = l_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
   assign ld_data = l_size == 2'b00 ? {{24{l_signed && ld_byte[7]}}, ld_byte} :
                    l_size == 2'b01 ? {{16{l_signed && ld_half[15]}}, ld_half} : dm_rdata;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         p4_valid <= 1'b0;
         p4_alu_rd <= '0;
         p4_alu_aluOut <= '0;
         p4_mem_rd <= '0;
         p4_mem_wen <= 1'b0;
         p4_mem_out <= '0;
         p4_misalign <= 1'b0;
         l_addr <= '0;
         l_we <= 1'b0;
         l_signed <= 1'b0;
         l_size <= 2'b00;
         l_wdata <= '0;
         l_rd <= '0;
         l_alu_rd <= '0;
         l_alu_out <= '0;
      end else if (state == IDLE) begin
         p4_valid <= p3_valid && !start;
         p4_mem_wen <= 1'b0;
         if (start) begin
            state <= BUSY;
            l_addr <= addr;
            l_we <= p3_mem_op == 2'b10;
            l_signed <= p3_mem_signed;
            l_size <= p3_mem_size;
            l_wdata <= p3_mem_wdata;
            l_rd <= p3_mem_rd;
            l_alu_rd <= p3_alu_rd;
            l_alu_out <= p3_alu_aluOut;
         end else if (p3_valid) begin
            p4_alu_rd <= p3_alu_rd;
            p4_alu_aluOut <= p3_alu_aluOut;
            p4_mem_rd <= '0;
            p4_misalign <= is_mem;
         end
      end else if (dm_ack) begin
         state <= IDLE;
         p4_valid <= 1'b1;
         p4_alu_rd <= l_alu_rd;
         p4_alu_aluOut <= l_alu_out;
         p4_mem_rd <= l_we ? '0 : l_rd;
         p4_mem_wen <= !l_we;
         p4_misalign <= 1'b0;
         if (!l_we) p4_mem_out <= ld_data;
      end else begin
         p4_valid <= 1'b0;
         p4_mem_wen <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed bench for mem_stage_hs with a transaction-level expectation queue and a per-cycle compare process.
module tb_mem_stage_hs;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        p3_valid = 1'b0;
   logic [5:0]  p3_alu_rd = '0;
   logic [63:0] p3_alu_aluOut = '0;
   logic [2:0]  p3_mem_rd = '0;
   logic [1:0]  p3_mem_op = '0;
   logic [1:0]  p3_mem_size = '0;
   logic        p3_mem_signed = 1'b0;
   logic [31:0] p3_mem_address = '0;
   logic [31:0] p3_mem_wdata = '0;
   logic        f_mem_address_sel = 1'b0;
   logic [31:0] f_mem_address = '0;
   logic        stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = 32'hDEAD0000;
   logic        p4_valid;
   logic [5:0]  p4_alu_rd;
   logic [63:0] p4_alu_aluOut;
   logic [2:0]  p4_mem_rd;
   logic        p4_mem_wen;
   logic [31:0] p4_mem_out;
   logic        p4_misalign;

   mem_stage_hs dut (
      .clk(clk), .reset(reset), .p3_valid(p3_valid), .p3_alu_rd(p3_alu_rd),
      .p3_alu_aluOut(p3_alu_aluOut), .p3_mem_rd(p3_mem_rd), .p3_mem_op(p3_mem_op),
      .p3_mem_size(p3_mem_size), .p3_mem_signed(p3_mem_signed),
      .p3_mem_address(p3_mem_address), .p3_mem_wdata(p3_mem_wdata),
      .f_mem_address_sel(f_mem_address_sel), .f_mem_address(f_mem_address),
      .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .p4_valid(p4_valid), .p4_alu_rd(p4_alu_rd), .p4_alu_aluOut(p4_alu_aluOut),
      .p4_mem_rd(p4_mem_rd), .p4_mem_wen(p4_mem_wen), .p4_mem_out(p4_mem_out),
      .p4_misalign(p4_misalign)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int          due;
      logic [5:0]  alu_rd;
      logic [63:0] alu_out;
      logic [2:0]  mem_rd;
      logic        chk_rd;
      logic        wen;
      logic [31:0] out;
      logic        misalign;
   } exp_t;
   exp_t q[$];

   logic        req_v = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] last_addr = '0;
   logic [31:0] last_wdata = '0;
   logic [3:0]  last_be = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // per-cycle compare of the memory port and the WB bundle against the expectation queue
   initial forever begin
      exp_t e;
      @(negedge clk);
      chk("dm_req", dm_req, req_v);
      if (dm_req) begin
         last_addr = dm_addr;
         last_be = dm_be;
         last_wdata = dm_wdata;
      end
      if (dm_req && req_v) begin
         chk("dm_addr", dm_addr, req_addr);
         chk("dm_we", dm_we, req_we);
         if (req_we) begin
            chk("dm_be", dm_be, req_be);
            chk("dm_wdata", dm_wdata, req_wdata);
         end
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("p4_valid", p4_valid, 1'b1);
         chk("p4_alu_rd", p4_alu_rd, e.alu_rd);
         chk("p4_alu_aluOut", p4_alu_aluOut, e.alu_out);
         chk("p4_misalign", p4_misalign, e.misalign);
         chk("p4_mem_wen", p4_mem_wen, e.wen);
         if (e.chk_rd) chk("p4_mem_rd", p4_mem_rd, e.mem_rd);
         if (e.wen) chk("p4_mem_out", p4_mem_out, e.out);
      end else begin
         chk("p4_valid_bubble", p4_valid, 1'b0);
         chk("p4_mem_wen_bubble", p4_mem_wen, 1'b0);
      end
   end

   task automatic step(inout int st);
      @(negedge clk);
      st = st + int'(stall);
      @(posedge clk);
      #1;
   endtask

   // d = number of BUSY cycles without ack before the ack cycle
   task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                        input logic [31:0] a3, input logic fsel, input logic [31:0] fa,
                        input logic [31:0] wd, input logic [2:0] rd, input logic [5:0] ard,
                        input logic [63:0] aout, input int d, input logic [31:0] rdata);
      logic [31:0] a;
      logic [31:0] v;
      logic [31:0] mask;
      logic        mem;
      logic        mis;
      int          nb;
      int          st;
      exp_t        e;
      a = fsel ? fa : a3;
      nb = size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
      mem = op == 2'b01 || op == 2'b10;
      mis = (a % nb) != 0;
      p3_valid = 1'b1;
      p3_mem_op = op;
      p3_mem_size = size;
      p3_mem_signed = sgn;
      p3_mem_address = a3;
      f_mem_address_sel = fsel;
      f_mem_address = fa;
      p3_mem_wdata = wd;
      p3_mem_rd = rd;
      p3_alu_rd = ard;
      p3_alu_aluOut = aout;
      mask = nb == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 1;
      v = (rdata >> (8 * a[1:0])) & mask;
      if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      e.alu_rd = ard;
      e.alu_out = aout;
      e.misalign = mem && mis;
      e.wen = op == 2'b01 && !mis;
      e.mem_rd = e.wen ? rd : 3'd0;
      e.chk_rd = !(op == 2'b01 && mis);
      e.out = v;
      st = 0;
      if (mem && !mis) begin
         e.due = cyc + 2 + d;
         q.push_back(e);
         req_addr = a - (a % 4);
         req_we = op == 2'b10;
         req_be = '0;
         for (int i = 0; i < nb; i++) req_be[int'(a[1:0]) + i] = 1'b1;
         for (int i = 0; i < 4; i++) req_wdata[8 * i +: 8] = wd[8 * (i % nb) +: 8];
         step(st);
         req_v = 1'b1;
         repeat (d) step(st);
         dm_ack = 1'b1;
         dm_rdata = rdata;
         step(st);
         dm_ack = 1'b0;
         dm_rdata = 32'hDEAD0000;
         req_v = 1'b0;
      end else begin
         e.due = cyc + 1;
         q.push_back(e);
         step(st);
      end
      chk("stall_cycles", st, (mem && !mis) ? 1 + d : 0);
      p3_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_p4_valid", p4_valid, 1'b0);
      chk("rst_p4_mem_wen", p4_mem_wen, 1'b0);
      chk("rst_p4_misalign", p4_misalign, 1'b0);
      chk("rst_p4_mem_out", p4_mem_out, 32'h0);
      chk("rst_p4_alu_aluOut", p4_alu_aluOut, 64'h0);
      chk("rst_dm_req", dm_req, 1'b0);
      chk("rst_dm_we", dm_we, 1'b0);
      chk("rst_dm_be", dm_be, 4'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      // ALU-only pass-through
      issue(2'b00, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, {3'd1, 3'd3}, {32'hCAFE0001, 32'h12345678}, 0, 32'h0);
      chk("t1_valid", p4_valid, 1'b1);
      chk("t1_slot0_rd", p4_alu_rd[2:0], 3'd3);
      chk("t1_slot0_out", p4_alu_aluOut[31:0], 32'h12345678);
      // signed byte load, three wait cycles
      issue(2'b01, 2'b00, 1'b1, 32'h103, 1'b0, 32'h0, 32'h0, 3'd5, {3'd2, 3'd4}, {32'h11, 32'h22}, 3, 32'h80FF_FF00);
      chk("t2_dm_addr", last_addr, 32'h100);
      chk("t2_mem_out", p4_mem_out, 32'hFFFF_FF80);
      chk("t2_mem_wen", p4_mem_wen, 1'b1);
      chk("t2_mem_rd", p4_mem_rd, 3'd5);
      // half store to upper half
      issue(2'b10, 2'b01, 1'b0, 32'h202, 1'b0, 32'h0, 32'h1234_BEEF, 3'd6, {3'd7, 3'd1}, {32'h33, 32'h44}, 1, 32'h0);
      chk("t3_be", last_be, 4'b1100);
      chk("t3_wdata_hi", last_wdata[31:16], 16'hBEEF);
      chk("t3_mem_wen", p4_mem_wen, 1'b0);
      chk("t3_mem_rd", p4_mem_rd, 3'd0);
      // misaligned word load
      issue(2'b01, 2'b10, 1'b0, 32'h101, 1'b0, 32'h0, 32'h0, 3'd2, {3'd1, 3'd1}, {32'h55, 32'h66}, 0, 32'h0);
      chk("t4_misalign", p4_misalign, 1'b1);
      chk("t4_mem_wen", p4_mem_wen, 1'b0);
      chk("t4_valid", p4_valid, 1'b1);
      // forwarded address, zero-extended half load, ack in first BUSY cycle
      issue(2'b01, 2'b01, 1'b0, 32'h80, 1'b1, 32'h40, 32'h0, 3'd3, {3'd5, 3'd6}, {32'h77, 32'h88}, 0, 32'h1234_ABCD);
      chk("t5_dm_addr", last_addr, 32'h40);
      chk("t5_mem_out", p4_mem_out, 32'h0000_ABCD);
      // additional patterns, some back-to-back
      issue(2'b01, 2'b01, 1'b1, 32'h206, 1'b0, 32'h0, 32'h0, 3'd1, {3'd0, 3'd2}, {32'h99, 32'hAA}, 2, 32'h8001_7FFF);
      chk("t7_mem_out", p4_mem_out, 32'hFFFF_8001);
      issue(2'b10, 2'b00, 1'b0, 32'h301, 1'b0, 32'h0, 32'h0000_00A5, 3'd4, {3'd3, 3'd3}, {32'hBB, 32'hCC}, 0, 32'h0);
      chk("t8_be", last_be, 4'b0010);
      chk("t8_wdata", last_wdata, 32'hA5A5_A5A5);
      issue(2'b01, 2'b00, 1'b0, 32'h402, 1'b0, 32'h0, 32'h0, 3'd7, {3'd6, 3'd5}, {32'hDD, 32'hEE}, 1, 32'h00C3_0000);
      chk("t9_mem_out", p4_mem_out, 32'h0000_00C3);
      issue(2'b01, 2'b11, 1'b1, 32'h500, 1'b0, 32'h0, 32'h0, 3'd2, {3'd4, 3'd4}, {32'h1, 32'h2}, 4, 32'h8765_4321);
      issue(2'b10, 2'b01, 1'b0, 32'h201, 1'b0, 32'h0, 32'h0000_1111, 3'd1, {3'd2, 3'd2}, {32'h3, 32'h4}, 0, 32'h0);
      chk("t11_misalign", p4_misalign, 1'b1);
      issue(2'b11, 2'b00, 1'b0, 32'h3, 1'b0, 32'h0, 32'h0, 3'd1, {3'd7, 3'd7}, {32'h5, 32'h6}, 0, 32'h0);
      chk("t12_misalign", p4_misalign, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      // reset during BUSY, then a late ack
      p3_valid = 1'b1;
      p3_mem_op = 2'b01;
      p3_mem_size = 2'b10;
      p3_mem_address = 32'h300;
      f_mem_address_sel = 1'b0;
      req_addr = 32'h300;
      req_we = 1'b0;
      @(posedge clk);
      #1;
      req_v = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      p3_valid = 1'b0;
      @(posedge clk);
      #1;
      req_v = 1'b0;
      reset = 1'b1;
      dm_ack = 1'b1;
      dm_rdata = 32'h1111_2222;
      chk("t6_dm_req", dm_req, 1'b0);
      chk("t6_stall", stall, 1'b0);
      chk("t6_p4_valid", p4_valid, 1'b0);
      @(posedge clk);
      #1;
      dm_ack = 1'b0;
      chk("t6_p4_valid_after_ack", p4_valid, 1'b0);
      chk("t6_dm_req_after_ack", dm_req, 1'b0);
      issue(2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, {3'd1, 3'd2}, {32'hABCD, 32'h1234}, 0, 32'h0);
      chk("t6_idle_after", p4_alu_aluOut[31:0], 32'h1234);
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
